// File: rtl/mem_arb_pkg.sv
// Shared types and latency limits for the two-requester memory port arbiter.
// Imported by mem_arb_pick and mem_port_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  // Wait counter holds MEM_LAT-1, so MEM_LAT_MAX-1 must fit.
  localparam int LAT_CNT_W   = 2;

  // Out-of-range latencies are pulled back into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IF and D requests; zero latency, no state.
// MEM_ARB_RR_EN: ties go to i_favour; otherwise D beats IF and i_favour is ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    i_if_req,
  input  logic    i_d_req,
  input  req_id_t i_favour,
  output logic    o_any,
  output req_id_t o_winner
);

  assign o_any = i_if_req | i_d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_winner = REQ_IF;
    if (i_if_req && i_d_req) begin
      o_winner = i_favour;
    end else if (i_d_req) begin
      o_winner = REQ_D;
    end
  end
`else
  logic w_unused_favour;
  assign w_unused_favour = i_favour;

  always_comb begin
    o_winner = REQ_IF;
    if (i_d_req) begin
      o_winner = REQ_D;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and D requesters via IDLE/ISSUE/WAIT/RESP.
// gnt one cycle after req is seen in IDLE, rvalid MEM_LAT+1 cycles after gnt; requesters hold req until gnt.
// MEM_ARB_RR_EN selects round-robin tie-breaking; default is fixed D-over-IF priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int                   LAT      = clamp_lat(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  req_id_t              r_id;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]    r_if_rdata;
  logic [DATA_W-1:0]    r_d_rdata;
  logic                 w_pick_any;
  req_id_t              w_pick_id;
  req_id_t              w_favour;
  logic                 w_latch;
  logic                 w_capture;

`ifdef MEM_ARB_RR_EN
  // Names the requester that wins the next tie: the one not granted last.
  req_id_t r_rr_ptr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rr_ptr <= REQ_IF;
    end else if (r_state == ISSUE) begin
      r_rr_ptr <= (r_id == REQ_IF) ? REQ_D : REQ_IF;
    end
  end

  assign w_favour = r_rr_ptr;
`else
  assign w_favour = REQ_IF;
`endif

  mem_arb_pick u_pick (
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .i_favour (w_favour),
    .o_any    (w_pick_any),
    .o_winner (w_pick_id)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_latch     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if_gnt      = (r_id == REQ_IF);
        d_gnt       = (r_id == REQ_D);
        mem_en      = 1'b1;
        mem_wen     = r_we;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        mem_en = 1'b1;
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if_rvalid   = (r_id == REQ_IF);
        d_rvalid    = (r_id == REQ_D);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The access is frozen at acceptance so requesters may move on after gnt.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_id    <= REQ_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_id <= w_pick_id;
      if (w_pick_id == REQ_D) begin
        r_we    <= d_we;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
      end else begin
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_cnt <= LAT_LOAD;
    end else if ((r_state == WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LAT_CNT_W'(1);
    end
  end

  // Writes leave both read-data registers untouched.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (w_capture && !r_we) begin
      if (r_id == REQ_D) begin
        r_d_rdata <= mem_data_out;
      end else begin
        r_if_rdata <= mem_data_out;
      end
    end
  end

  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT 1 and 3) share one random requester pair; a transaction-level
// model predicts every output cycle by cycle from the latency and priority rules.
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int M_DIR = 0;
  localparam int M_RND = 1;
  localparam int M_MAN = 2;

  typedef struct {
    int            start;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic [1:0]    o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_en, o_wen, o_busy;
  logic [DW-1:0] o_if_rd [2];
  logic [DW-1:0] o_d_rd  [2];
  logic [DW-1:0] o_din   [2];
  logic [DW-1:0] mdo     [2];
  logic [AW-1:0] o_addr  [2];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .clr_n(clr_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[0]), .if_rvalid(o_if_rv[0]),
    .if_rdata(o_if_rd[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o_d_gnt[0]),
    .d_rvalid(o_d_rv[0]), .d_rdata(o_d_rd[0]),
    .mem_en(o_en[0]), .mem_wen(o_wen[0]), .mem_addr(o_addr[0]), .mem_data_in(o_din[0]),
    .mem_data_out(mdo[0]), .busy(o_busy[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .clr_n(clr_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[1]), .if_rvalid(o_if_rv[1]),
    .if_rdata(o_if_rd[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(o_d_gnt[1]),
    .d_rvalid(o_d_rv[1]), .d_rdata(o_d_rd[1]),
    .mem_en(o_en[1]), .mem_wen(o_wen[1]), .mem_addr(o_addr[1]), .mem_data_in(o_din[1]),
    .mem_data_out(mdo[1]), .busy(o_busy[1])
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (32'h9E37_79B9 * {24'd0, a}) + 32'h0BAD_F00D;
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Behavioural single-port memories with a MEM_LAT-deep read pipeline.
  logic [DW-1:0] env_mem [2][256];
  logic          env_wr  [2][256] = '{default: 1'b0};
  logic [DW-1:0] pipe    [2][4];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (o_en[u]) begin
        pipe[u][0] <= env_wr[u][o_addr[u]] ? env_mem[u][o_addr[u]] : init_val(o_addr[u]);
        for (int s = 1; s < 4; s++) pipe[u][s] <= pipe[u][s-1];
        if (o_wen[u]) begin
          env_mem[u][o_addr[u]] <= o_din[u];
          env_wr[u][o_addr[u]]  <= 1'b1;
        end
      end
    end
  end

  assign mdo[0] = pipe[0][0];
  assign mdo[1] = pipe[1][2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = M_DIR;

  int            nf [2];
  bit            has [2];
  int            t_gnt [2];
  int            t_rv [2];
  bit            t_d [2];
  bit            t_we [2];
  logic [AW-1:0] t_addr [2];
  logic [DW-1:0] t_wd [2];
  logic [DW-1:0] t_rd [2];
  logic [DW-1:0] e_if_rd [2];
  logic [DW-1:0] e_d_rd [2];
  logic [DW-1:0] ref_mem [2][256];
  bit            e_if_gnt [2];
  bit            e_d_gnt [2];
  bit            if_got [2];
  bit            d_got [2];
`ifdef MEM_ARB_RR_EN
  bit            favour_d [2];
`endif
  logic          man_if_req;
  logic [AW-1:0] man_if_addr;
  dreq_t         dq_if [$];
  dreq_t         dq_d [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int u = 0; u < 2; u++) begin
      string p;
      p = $sformatf("%s L%0d ", tag, lat_of(u));
      chk({p, "busy"},      64'(o_busy[u]),   64'd0);
      chk({p, "if_gnt"},    64'(o_if_gnt[u]), 64'd0);
      chk({p, "d_gnt"},     64'(o_d_gnt[u]),  64'd0);
      chk({p, "if_rvalid"}, 64'(o_if_rv[u]),  64'd0);
      chk({p, "d_rvalid"},  64'(o_d_rv[u]),   64'd0);
      chk({p, "mem_en"},    64'(o_en[u]),     64'd0);
      chk({p, "mem_wen"},   64'(o_wen[u]),    64'd0);
      chk({p, "mem_addr"},  64'(o_addr[u]),   64'd0);
      chk({p, "mem_din"},   64'(o_din[u]),    64'd0);
      chk({p, "if_rdata"},  64'(o_if_rd[u]),  64'd0);
      chk({p, "d_rdata"},   64'(o_d_rd[u]),   64'd0);
    end
  endtask

  task automatic check_cycle();
    for (int u = 0; u < 2; u++) begin
      bit    in_t, e_rv, e_en, e_issue;
      string p;
      p       = $sformatf("L%0d ", lat_of(u));
      in_t    = has[u] && (cyc >= t_gnt[u]) && (cyc <= t_rv[u]);
      e_rv    = in_t && (cyc == t_rv[u]);
      e_en    = in_t && (cyc < t_rv[u]);
      e_issue = in_t && (cyc == t_gnt[u]);
      e_if_gnt[u] = e_issue && !t_d[u];
      e_d_gnt[u]  = e_issue && t_d[u];
      if (e_rv && !t_we[u]) begin
        if (t_d[u]) e_d_rd[u] = t_rd[u];
        else        e_if_rd[u] = t_rd[u];
      end
      chk({p, "busy"},      64'(o_busy[u]),   64'(in_t));
      chk({p, "if_gnt"},    64'(o_if_gnt[u]), 64'(e_if_gnt[u]));
      chk({p, "d_gnt"},     64'(o_d_gnt[u]),  64'(e_d_gnt[u]));
      chk({p, "mem_en"},    64'(o_en[u]),     64'(e_en));
      chk({p, "mem_wen"},   64'(o_wen[u]),    64'(e_issue && t_we[u]));
      chk({p, "if_rvalid"}, 64'(o_if_rv[u]),  64'(e_rv && !t_d[u]));
      chk({p, "d_rvalid"},  64'(o_d_rv[u]),   64'(e_rv && t_d[u]));
      chk({p, "if_rdata"},  64'(o_if_rd[u]),  64'(e_if_rd[u]));
      chk({p, "d_rdata"},   64'(o_d_rd[u]),   64'(e_d_rd[u]));
      if (e_en)                chk({p, "mem_addr"}, 64'(o_addr[u]), 64'(t_addr[u]));
      if (e_issue && t_we[u])  chk({p, "mem_din"},  64'(o_din[u]),  64'(t_wd[u]));
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
    return AW'($urandom);
  endfunction

  task automatic drive_stage();
    for (int u = 0; u < 2; u++) begin
      if (e_if_gnt[u]) if_got[u] = 1'b1;
      if (e_d_gnt[u])  d_got[u]  = 1'b1;
    end
    if (mode == M_MAN) begin
      if_req  = man_if_req;
      if_addr = man_if_addr;
      d_req   = 1'b0;
      return;
    end
    if (if_req && ((if_got[0] && if_got[1]) || (mode == M_RND && $urandom_range(0, 31) == 0)))
      if_req = 1'b0;
    if (d_req && ((d_got[0] && d_got[1]) || (mode == M_RND && $urandom_range(0, 31) == 0)))
      d_req = 1'b0;
    if (!if_req) begin
      if (mode == M_DIR) begin
        if (dq_if.size() > 0 && cyc >= dq_if[0].start) begin
          if_addr = dq_if[0].addr;
          void'(dq_if.pop_front());
          if_req = 1'b1;
          if_got = '{1'b0, 1'b0};
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_addr = rnd_addr();
        if_req  = 1'b1;
        if_got  = '{1'b0, 1'b0};
      end
    end
    if (!d_req) begin
      if (mode == M_DIR) begin
        if (dq_d.size() > 0 && cyc >= dq_d[0].start) begin
          d_we    = dq_d[0].we;
          d_addr  = dq_d[0].addr;
          d_wdata = dq_d[0].wdata;
          void'(dq_d.pop_front());
          d_req = 1'b1;
          d_got = '{1'b0, 1'b0};
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rnd_addr();
        d_wdata = $urandom;
        d_req   = 1'b1;
        d_got   = '{1'b0, 1'b0};
      end
    end
  endtask

  // A free port accepts whatever is requested now: gnt next cycle, rvalid lat+1 later.
  task automatic model_stage();
    for (int u = 0; u < 2; u++) begin
      if (cyc >= nf[u] && (if_req || d_req)) begin
        bit pick_d;
        if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
          pick_d = favour_d[u];
`else
          pick_d = 1'b1;
`endif
        end else begin
          pick_d = d_req;
        end
`ifdef MEM_ARB_RR_EN
        favour_d[u] = !pick_d;
`endif
        has[u]    = 1'b1;
        t_d[u]    = pick_d;
        t_we[u]   = pick_d && d_we;
        t_addr[u] = pick_d ? d_addr : if_addr;
        t_wd[u]   = d_wdata;
        t_gnt[u]  = cyc + 1;
        t_rv[u]   = cyc + 2 + lat_of(u);
        nf[u]     = cyc + 3 + lat_of(u);
        if (t_we[u]) ref_mem[u][t_addr[u]] = d_wdata;
        else         t_rd[u] = ref_mem[u][t_addr[u]];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_cycle();
    drive_stage();
    model_stage();
    cyc++;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      has[u]     = 1'b0;
      nf[u]      = cyc;
      e_if_rd[u] = '0;
      e_d_rd[u]  = '0;
`ifdef MEM_ARB_RR_EN
      favour_d[u] = 1'b0;
`endif
    end
  endtask

  initial begin
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    man_if_req = 1'b0; man_if_addr = '0;
    clr_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 256; a++) ref_mem[u][a] = init_val(AW'(a));
      e_if_gnt[u] = 1'b0; e_d_gnt[u] = 1'b0;
      if_got[u] = 1'b0; d_got[u] = 1'b0;
    end
    model_reset();
    dq_d.push_back('{0,  1'b1, 8'h10, 32'hDEAD_BEEF});
    dq_d.push_back('{6,  1'b0, 8'h20, 32'h0});
    dq_if.push_back('{6, 1'b0, 8'h10, 32'h0});
    dq_d.push_back('{22, 1'b1, 8'h05, 32'h1234_5678});
    dq_d.push_back('{32, 1'b0, 8'h05, 32'h0});
    dq_if.push_back('{32, 1'b0, 8'h05, 32'h0});
    dq_if.push_back('{44, 1'b0, 8'hFF, 32'h0});

    #1 clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    clr_n = 1'b1;

    repeat (60) step();
    mode = M_RND;
    repeat (1500) step();
    mode = M_MAN;
    repeat (16) step();

    // Abort an IF read while both ports sit in WAIT.
    man_if_req = 1'b1; man_if_addr = 8'h05;
    step();
    man_if_req = 1'b0;
    step();
    step();
    #2 clr_n = 1'b0;
    if_req = 1'b0;
    #1 check_zero("mid_rst");
    model_reset();
    #2 clr_n = 1'b1;
    repeat (10) step();

    man_if_req = 1'b1; man_if_addr = 8'h10;
    step();
    man_if_req = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory_unit between two requesters: instruction fetch (IF) and data load/store (D).
- Runs in the processor clock domain. Sequences every access through a fixed issue/wait/respond cycle and returns read data with a one-cycle valid pulse.
- Lets the single-cycle core migrate to a unified instruction/data memory, and lets the multi-cycle controller share the port.

Parameters:
- ADDR_W, 8, word address width driven to memory_unit.
- DATA_W, 32, data bus width.
- MEM_LAT, 1, memory read latency in cycles (legal range 1..4).

Ports:
- clk  input  1  processor clock, rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- if_req  input  1  IF access request; held with if_addr until if_gnt.
- if_addr  input  ADDR_W  IF word address.
- if_gnt  output  1  one-cycle pulse: IF request accepted.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  DATA_W  IF read data, held until the next IF response.
- d_req  input  1  D access request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  D word address.
- d_wdata  input  DATA_W  D write data.
- d_gnt  output  1  one-cycle pulse: D request accepted.
- d_rvalid  output  1  one-cycle pulse: D read data valid, or write acknowledged.
- d_rdata  output  DATA_W  D read data, held until the next D read response.
- mem_en  output  1  memory chip enable.
- mem_wen  output  1  memory write enable, active-high.
- mem_addr  output  ADDR_W  memory address.
- mem_data_in  output  DATA_W  memory write data.
- mem_data_out  input  DATA_W  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = IDLE.
  - All outputs 0; rdata registers cleared.
  - Round-robin pointer = IF. Wait counter = 0.
  - An access in flight is aborted: no gnt or rvalid is emitted for it after reset releases.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, latch the winner's id, address, we and wdata; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Winner's gnt = 1.
  - mem_en = 1; mem_addr and mem_data_in come from the latched request.
  - mem_wen = latched we (IF is always a read).
  - Go to WAIT with counter = MEM_LAT−1.
- WAIT:
  - mem_en = 1, mem_wen = 0, address held.
  - When counter = 0: capture mem_data_out into the winner's rdata register (reads only) and go to RESP.
  - Otherwise decrement the counter.
- RESP (1 cycle):
  - Winner's rvalid = 1.
  - For a D write, d_rvalid pulses and d_rdata is left unchanged.
  - Go to IDLE.
- Latency: req high at cycle t (state IDLE) → gnt at t+1 → rvalid at t+2+MEM_LAT. For MEM_LAT=1, rvalid at t+3.
- Throughput: one access per 3+MEM_LAT cycles.
- Default priority is fixed: when both requesters are high, D wins over IF.
- A requester that drops req before gnt is simply not granted; no error.
- A req that stays high after its gnt is treated as a new request at the next IDLE.
- if_gnt and d_gnt are never high in the same cycle; likewise if_rvalid and d_rvalid.
- Addresses pass through unmodified; there is no wrap or bounds logic, and the full ADDR_W is used.
- Requester inputs may change after gnt without affecting the access in flight.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester not granted last wins. The pointer updates on every grant and resets to favour IF.
- MEM_ARB_RR_EN undefined: fixed D-over-IF priority and no pointer register.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - typedef enum logic req_id_t {REQ_IF=0, REQ_D=1};
  - the MEM_LAT legal-range constants.
- Sub-module mem_arb_pick: combinational winner selection from if_req, d_req and the last-grant pointer. The pointer input is ignored when MEM_ARB_RR_EN is undefined.

Test Plan:
- IF read alone:
  - Stimulus: MEM_LAT=1, memory word 0x10 = 0xDEADBEEF; if_req=1, if_addr=0x10 at cycle 0.
  - Required: if_gnt at cycle 1 with mem_addr=0x10 and mem_en=1; if_rvalid at cycle 3 with if_rdata=0xDEADBEEF.
- Simultaneous requests, default build:
  - Stimulus: if_req and d_req both high (D read at 0x20).
  - Required: d_gnt at cycle 1. if_gnt at cycle 5 (re-arbitration in IDLE at cycle 4). if_gnt and d_gnt never coincide.
- Round-robin, MEM_ARB_RR_EN defined:
  - Stimulus: both requesters held high for 16 cycles.
  - Required: grant order IF, D, IF, D.
- D write:
  - Stimulus: d_we=1, d_addr=0x05, d_wdata=0x12345678.
  - Required: mem_wen=1 only in the ISSUE cycle; d_rvalid pulses; d_rdata unchanged; a following read of 0x05 returns 0x12345678.
- Reset mid-operation:
  - Stimulus: clr_n pulled low during WAIT.
  - Required: all outputs immediately 0; after release, no rvalid for the aborted access; busy=0.
- MEM_LAT=3:
  - Stimulus: IF read issued at cycle 0.
  - Required: rvalid at cycle 5; busy high for cycles 1–5.
